// File: rtl/int2float_share_ctrl.sv
// rtl/int2float_share_ctrl.sv - round-robin time-sharing controller for one int2float converter
module int2float_share_ctrl #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int CONV_LAT = 2,
  parameter int CNTW     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*11-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [10:0]       conv_b,
  input  logic [3:0]        conv_m,
  input  logic [2:0]        conv_e,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_m,
  output logic [2:0]        rsp_e,
  output logic              busy,
  output logic [CNTW-1:0]   conv_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [10:0]     conv_b_q, conv_b_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [3:0]      rsp_m_q, rsp_m_d;
  logic [2:0]      rsp_e_q, rsp_e_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            busy_q, busy_d;
  logic [CNTW-1:0] conv_count_q, conv_count_d;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin : arb
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    conv_b_d     = conv_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_m_d      = rsp_m_q;
    rsp_e_d      = rsp_e_q;
    conv_count_d = conv_count_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          conv_b_d = req_b[11*gnt_idx +: 11];
          rsp_id_d = gnt_idx;
          rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
          cnt_d    = 4'(CONV_LAT - 1);
          state_d  = CONV;
        end
      end
      CONV: begin
        // conv_b has been stable for CONV_LAT cycles when the counter hits zero.
        if (cnt_q == 4'd0) begin
          rsp_m_d = conv_m;
          rsp_e_d = conv_e;
          if (~&conv_count_q) conv_count_d = conv_count_q + 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      conv_b_q     <= '0;
      rsp_id_q     <= '0;
      rsp_m_q      <= '0;
      rsp_e_q      <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      conv_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      conv_b_q     <= conv_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_m_q      <= rsp_m_d;
      rsp_e_q      <= rsp_e_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      conv_count_q <= conv_count_d;
    end
  end

  assign conv_b     = conv_b_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_m      = rsp_m_q;
  assign rsp_e      = rsp_e_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = busy_q;
  assign conv_count = conv_count_q;

endmodule

// File: tb/tb_int2float_share_ctrl.sv
// tb/tb_int2float_share_ctrl.sv - self-checking bench for int2float_share_ctrl
module tb_int2float_share_ctrl;
  localparam int NREQ = 4, IDW = 2, CONV_LAT = 2, CNTW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*11-1:0] req_b;
  logic [10:0]       conv_b;
  logic [3:0]        conv_m, rsp_m;
  logic [2:0]        conv_e, rsp_e;
  logic              rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]    rsp_id;
  logic [CNTW-1:0]   conv_count;

  always #5 clk = ~clk;

  assign conv_m = conv_b[3:0];
  assign conv_e = conv_b[6:4];

  int2float_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .CONV_LAT(CONV_LAT), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_b(req_b), .req_ready(req_ready),
    .conv_b(conv_b), .conv_m(conv_m), .conv_e(conv_e), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_m(rsp_m), .rsp_e(rsp_e),
    .busy(busy), .conv_count(conv_count)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: one job in flight, result due CONV_LAT+1 cycles after grant.
  int          m_ptr, m_id, m_count, cyc, m_ready_at;
  bit          m_pending, prev_grant;
  logic [10:0] m_opnd, prev_conv_b;

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_count = 0; m_pending = 0; m_opnd = '0;
    prev_conv_b = '0; prev_grant = 0; m_ready_at = 0;
  endtask

  // Called at the falling edge: compare, advance the model, then move to just after the rising edge.
  task automatic step();
    int g;
    logic [3:0] er;
    bit ev;
    g = -1;
    if (!m_pending)
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    er = (g >= 0) ? 4'(1 << g) : 4'b0;
    ev = m_pending && (cyc >= m_ready_at);
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(m_pending));
    chk("conv_b", 32'(conv_b), 32'(m_opnd));
    chk("conv_count", 32'(conv_count), 32'(m_count));
    if (ev) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_m", 32'(rsp_m), 32'(m_opnd[3:0]));
      chk("rsp_e", 32'(rsp_e), 32'(m_opnd[6:4]));
    end
    if (conv_b !== prev_conv_b) chk("conv_b_only_on_grant", 32'(prev_grant), 32'd1);
    prev_conv_b = conv_b;
    prev_grant  = (g >= 0);
    if (m_pending && cyc == m_ready_at - 1 && m_count < 15) m_count++;
    if (ev && rsp_ready) m_pending = 0;
    if (g >= 0) begin
      m_pending  = 1;
      m_ready_at = cyc + CONV_LAT + 1;
      m_opnd     = req_b[11*g +: 11];
      m_ptr      = (g + 1) % NREQ;
      m_id       = g;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_conv_b", 32'(conv_b), 0);
    chk("rst_conv_count", 32'(conv_count), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_req_ready_hold", 32'(req_ready), 0);
    rst_n = 1'b1;
    req_valid = '0;
  endtask

  typedef struct {
    logic [3:0] rv; logic rr; logic [3:0] ready; logic vld;
    logic [1:0] id; logic [3:0] m; logic [2:0] e; logic [3:0] cnt;
  } vec_t;
  vec_t tbl[12];

  localparam logic [NREQ*11-1:0] FIXED_B = {11'h3C7, 11'h05A, 11'h1B3, 11'h024};

  int  gnt_ids[$], gnt_cyc[$];
  bit  found;
  logic [IDW-1:0] s_id;
  logic [3:0] s_m;
  logic [2:0] s_e;
  logic [10:0] s_b;

  initial begin
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 4'h0, 3'd0, 4'd0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 3'd0, 4'd0};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 3'd0, 4'd0};
    tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 4'hA, 3'd5, 4'd1};
    tbl[4]  = '{4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, 4'h0, 3'd0, 4'd1};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 3'd0, 4'd1};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 3'd0, 4'd1};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 4'h3, 3'd3, 4'd2};
    tbl[8]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 4'h0, 3'd0, 4'd2};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 3'd0, 4'd2};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 3'd0, 4'd2};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 4'h4, 3'd2, 4'd3};

    rst_n = 1'b0; req_valid = '0; req_b = '0; rsp_ready = 1'b0; cyc = 0;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Single request, pointer skip and wrap
    req_b = FIXED_B;
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].rv;
      rsp_ready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_count", i), 32'(conv_count), 32'(tbl[i].cnt));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_id", i), 32'(rsp_id), 32'(tbl[i].id));
        chk($sformatf("tbl%0d_m", i), 32'(rsp_m), 32'(tbl[i].m));
        chk($sformatf("tbl%0d_e", i), 32'(rsp_e), 32'(tbl[i].e));
      end
      step();
    end

    // Round robin under full load
    apply_reset();
    req_b = FIXED_B; req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++)
        if (req_ready[k]) begin gnt_ids.push_back(k); gnt_cyc.push_back(c); end
      step();
    end
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("rr_id%0d", j), (j < gnt_ids.size()) ? 32'(gnt_ids[j]) : 32'hFFFF, 32'(j % NREQ));
      if (j > 0)
        chk($sformatf("rr_gap%0d", j),
            (j < gnt_cyc.size()) ? 32'(gnt_cyc[j] - gnt_cyc[j-1]) : 32'hFFFF, 32'(CONV_LAT + 2));
    end

    // Backpressure
    apply_reset();
    req_valid = '1; rsp_ready = 1'b0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid) found = 1;
      else step();
    end
    chk("bp_rsp_seen", 32'(found), 1);
    s_id = rsp_id; s_m = rsp_m; s_e = rsp_e; s_b = conv_b;
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_id", 32'(rsp_id), 32'(s_id));
      chk("bp_hold_m", 32'(rsp_m), 32'(s_m));
      chk("bp_hold_e", 32'(rsp_e), 32'(s_e));
      chk("bp_hold_conv_b", 32'(conv_b), 32'(s_b));
      chk("bp_no_grant", 32'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_pulse_valid", 32'(rsp_valid), 1);
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready != 0), 1);
    chk("bp_one_consumed", 32'(rsp_valid), 0);
    step();

    // Reset one cycle after a grant
    apply_reset();
    req_b = FIXED_B; req_valid = 4'b0100; rsp_ready = 1'b1;
    @(negedge clk);
    step();
    req_valid = '0;
    #3;
    apply_reset();
    req_valid = '1;
    @(negedge clk);
    chk("rst_ptr_grant0", 32'(req_ready), 32'b0001);
    chk("rst_no_rsp", 32'(rsp_valid), 0);
    step();

    // Saturation: 20 back-to-back conversions
    apply_reset();
    req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 20 * (CONV_LAT + 2); c++) begin
      req_b = 44'({$urandom(), $urandom()});
      @(negedge clk);
      step();
    end
    @(negedge clk);
    chk("sat_conv_count", 32'(conv_count), 32'hF);
    step();

    // Randomized traffic against the reference model
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_b     = 44'({$urandom(), $urandom()});
      @(negedge clk);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/int2float_share_ctrl.md
Name: int2float_share_ctrl

Overview:
- Time-shares one combinational int2float converter (11-bit integer in; 4-bit mantissa M and 3-bit exponent E out) among NREQ requesters.
- Performs round-robin arbitration and holds the converter input stable for a configurable settle window, treated as a multicycle path.
- Returns each result tagged with the requester index over a valid/ready response channel.
- Sits between the requesting datapath clients and the single shared converter instance, in the low-power datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-id width; must satisfy 2**IDW >= NREQ.
- CONV_LAT, 2, cycles conv_b is held before conv_m/conv_e are sampled (1..15).
- CNTW, 16, width of the saturating conversion counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_b  in  NREQ*11  per-requester integer operand; requester i uses bits [11*i+10 : 11*i].
- req_ready  out  NREQ  one-hot grant/accept, combinational.
- conv_b  out  11  registered operand driven to the shared converter.
- conv_m  in  4  converter mantissa result.
- conv_e  in  3  converter exponent result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester index of the response.
- rsp_m  out  4  registered mantissa.
- rsp_e  out  3  registered exponent.
- busy  out  1  high when the state is not IDLE.
- conv_count  out  CNTW  completed conversions, saturating.

Behaviour:
- Reset (asynchronous, effective immediately):
  - State = IDLE; rr_ptr = 0; settle counter = 0.
  - conv_b = 0, rsp_valid = 0, rsp_id = 0, rsp_m = 0, rsp_e = 0, busy = 0, conv_count = 0.
  - req_ready = 0 while rst_n is low.
- FSM has three states: IDLE, CONV, RESP.
- IDLE:
  - If any req_valid is high, grant g = the first index with req_valid set, searching from rr_ptr upward with wrap-around modulo NREQ.
  - req_ready[g] = 1 in that same cycle; all other req_ready bits are 0.
  - At the clock edge: conv_b <= req_b[g], rsp_id <= g, rr_ptr <= (g+1) mod NREQ, settle counter <= CONV_LAT-1, go to CONV.
  - With no req_valid high: stay in IDLE, req_ready = 0, and all registers hold.
- CONV:
  - req_ready = 0.
  - Counter decrements each cycle.
  - In the cycle the counter reads 0: rsp_m <= conv_m, rsp_e <= conv_e, conv_count increments (holds at all-ones), go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_m and rsp_e are stable until the handshake completes.
  - On rsp_valid & rsp_ready: go to IDLE; rsp_valid falls on the next cycle.
  - rsp_ready low: hold indefinitely. No new grant is issued, so requesters see backpressure.
- Latency: for a grant in cycle t with rsp_ready held high:
  - conv_b is valid from t+1.
  - conv_m/conv_e are sampled at the end of cycle t+CONV_LAT.
  - rsp_valid is high in cycle t+CONV_LAT+1.
  - The next grant can occur at t+CONV_LAT+2 at the earliest.
- Power rule: conv_b changes only on a grant. It is held through CONV, RESP and IDLE and is never cleared after use, so the converter does not toggle.
- req_b is sampled only in the grant cycle; later changes to it are ignored.
- A requester that drops req_valid before being granted is simply skipped. The request is not remembered.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,..,NREQ-1,0,...; no requester waits more than NREQ-1 other grants.
- Reset mid-operation (CONV or RESP): the in-flight result is discarded, no response is emitted, and rr_ptr returns to 0.
- Indices >= NREQ are never granted.

Test Plan:
Benches use a converter stub with conv_m = conv_b[3:0] and conv_e = conv_b[6:4].
1. Single request: CONV_LAT=2, req_valid=4'b0100, req_b[2]=11'h05A, rsp_ready=1 → req_ready=4'b0100 at t; rsp_valid at t+3 with rsp_id=2, rsp_m=4'hA, rsp_e=3'h5; conv_count=1.
2. Round-robin: req_valid=4'b1111 held for 8 transactions → rsp_id sequence 0,1,2,3,0,1,2,3; one grant every 4 cycles.
3. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_* outputs stable, req_ready=0 throughout, conv_b unchanged; a single rsp_ready pulse → exactly one response consumed, next grant on the following cycle.
4. Pointer skip and wrap: rr_ptr=3 with req_valid=4'b0010 → grant 1; next rr_ptr=2. Then req_valid=4'b0001 → grant 0.
5. Reset mid-CONV: assert rst_n=0 one cycle after a grant → all outputs return to reset values immediately, no rsp_valid, rr_ptr=0, conv_count=0.
6. Saturation/power: CNTW=4, run 20 conversions → conv_count=4'hF. conv_b toggles only on grant cycles, checked by assertion.
